// File: rtl/msgpass_mp_buffer_pkg.sv
// Shared configuration for the VNU/CNU message-passing buffer: default widths,
// clear-engine state encoding and a helper for flattened per-port bus slicing.
package msgPass_config_pkg;

    localparam int MSGPASS_BUFF_RDATA_WIDTH = 8;
    localparam int MSGPASS_BUFF_ADDR_WIDTH  = 6;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } msgpass_buf_state_e;

    // Base bit index of port p inside a flattened bus of w-bit lanes.
    function automatic int port_slice(input int p, input int w);
        return p * w;
    endfunction

endpackage

// File: rtl/msgpass_wr_arbiter.sv
// Per-entry write-enable/data selection for the message buffer. While the clear
// sweep runs it owns the array and zeroes one entry per cycle; otherwise each
// entry takes the highest-indexed port that targets it. Out-of-range addresses
// never match an entry, so they fall away here without extra logic.
module msgpass_wr_arbiter
    import msgPass_config_pkg::*;
#(
    parameter int DATA_WIDTH = MSGPASS_BUFF_RDATA_WIDTH,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int PORT_NUM   = 2
)(
    input  logic [PORT_NUM-1:0]            wen_i,
    input  logic [PORT_NUM*ADDR_WIDTH-1:0] waddr_i,
    input  logic [PORT_NUM*DATA_WIDTH-1:0] wdata_i,
    input  logic                           busy_i,
    input  logic [ADDR_WIDTH-1:0]          clr_addr_i,
    output logic [DEPTH-1:0]               ent_we_o,
    output logic [DATA_WIDTH-1:0]          ent_wd_o [DEPTH]
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic                  we;
        logic [DATA_WIDTH-1:0] wd;

        // Sweep override while busy, else later (higher) ports overwrite earlier matches.
        always_comb begin
            we = 1'b0;
            wd = '0;
            if (busy_i) begin
                if (clr_addr_i == ADDR_WIDTH'(gi)) begin
                    we = 1'b1;
                end
            end else begin
                for (int p = 0; p < PORT_NUM; p++) begin
                    if (wen_i[p] &&
                        waddr_i[port_slice(p, ADDR_WIDTH) +: ADDR_WIDTH] == ADDR_WIDTH'(gi)) begin
                        we = 1'b1;
                        wd = wdata_i[port_slice(p, DATA_WIDTH) +: DATA_WIDTH];
                    end
                end
            end
        end

        assign ent_we_o[gi] = we;
        assign ent_wd_o[gi] = wd;
    end

endmodule

// File: rtl/msgpass_mp_buffer.sv
// Multi-port message buffer between the VNU and CNU stages: PORT_NUM write and
// read ports, write-first bypass, 1- or 2-cycle read latency, a sticky error
// flag and a one-entry-per-cycle clear sweep. Storage contents survive reset.
module msgpass_mp_buffer
    import msgPass_config_pkg::*;
#(
    parameter int DATA_WIDTH = MSGPASS_BUFF_RDATA_WIDTH,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int PORT_NUM   = 2,
    parameter int RD_LAT     = 1
)(
    input  logic                           clk_i,
    input  logic                           rst,
    input  logic                           clr_req_i,
    output logic                           busy_o,
    input  logic [PORT_NUM-1:0]            wen_i,
    input  logic [PORT_NUM*ADDR_WIDTH-1:0] waddr_i,
    input  logic [PORT_NUM*DATA_WIDTH-1:0] wdata_i,
    input  logic [PORT_NUM-1:0]            ren_i,
    input  logic [PORT_NUM*ADDR_WIDTH-1:0] raddr_i,
    output logic [PORT_NUM*DATA_WIDTH-1:0] rdata_o,
    output logic [PORT_NUM-1:0]            rvalid_o,
    output logic                           err_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam bit                    FULL_RANGE = ((1 << ADDR_WIDTH) == DEPTH);

    msgpass_buf_state_e    state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      ent_we;
    logic [DATA_WIDTH-1:0] ent_wd [DEPTH];
    logic [PORT_NUM-1:0]   wbad, rbad;

    assign busy_o = (state_q == CLEAR);
    assign err_o  = err_q;

    msgpass_wr_arbiter #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PORT_NUM   (PORT_NUM)
    ) u_wr_arbiter (
        .wen_i      (wen_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .busy_i     (busy_o),
        .clr_addr_i (cnt_q),
        .ent_we_o   (ent_we),
        .ent_wd_o   (ent_wd)
    );

    // Address range checks only exist when DEPTH leaves unused codes.
    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_range
        if (FULL_RANGE) begin : g_full
            assign wbad[gi] = 1'b0;
            assign rbad[gi] = 1'b0;
        end else begin : g_part
            assign wbad[gi] = (waddr_i[port_slice(gi, ADDR_WIDTH) +: ADDR_WIDTH] >= ADDR_WIDTH'(DEPTH));
            assign rbad[gi] = (raddr_i[port_slice(gi, ADDR_WIDTH) +: ADDR_WIDTH] >= ADDR_WIDTH'(DEPTH));
        end
    end

    // Clear engine: enter on request, zero entry cnt each cycle, leave after the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky error: any access that is out of range or lands during the sweep.
    always_comb begin
        err_d = err_q
              | (|(wen_i & (wbad | {PORT_NUM{busy_o}})))
              | (|(ren_i & (rbad | {PORT_NUM{busy_o}})));
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Storage array; deliberately not reset so contents persist across rst.
    always_ff @(posedge clk_i) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (ent_we[e]) begin
                mem_q[e] <= ent_wd[e];
            end
        end
    end

    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd_word;
        logic                  s1_vld_q, s1_vld_d;
        logic [DATA_WIDTH-1:0] s1_dat_q, s1_dat_d;

        assign ra = raddr_i[port_slice(gi, ADDR_WIDTH) +: ADDR_WIDTH];

        // Write-first lookup; bad addresses and reads during the sweep return zero.
        always_comb begin
            rd_word = '0;
            if (!busy_o && !rbad[gi]) begin
                rd_word = ent_we[ra] ? ent_wd[ra] : mem_q[ra];
            end
        end

        // First read stage: data only moves on a request so it holds otherwise.
        always_comb begin
            s1_vld_d = ren_i[gi];
            s1_dat_d = ren_i[gi] ? rd_word : s1_dat_q;
        end

        // First read stage registers.
        always_ff @(posedge clk_i or posedge rst) begin
            if (rst) begin
                s1_vld_q <= 1'b0;
                s1_dat_q <= '0;
            end else begin
                s1_vld_q <= s1_vld_d;
                s1_dat_q <= s1_dat_d;
            end
        end

        if (RD_LAT == 2) begin : g_lat2
            logic                  s2_vld_q, s2_vld_d;
            logic [DATA_WIDTH-1:0] s2_dat_q, s2_dat_d;

            // Second read stage: forward stage-one result, hold data when idle.
            always_comb begin
                s2_vld_d = s1_vld_q;
                s2_dat_d = s1_vld_q ? s1_dat_q : s2_dat_q;
            end

            // Second read stage registers.
            always_ff @(posedge clk_i or posedge rst) begin
                if (rst) begin
                    s2_vld_q <= 1'b0;
                    s2_dat_q <= '0;
                end else begin
                    s2_vld_q <= s2_vld_d;
                    s2_dat_q <= s2_dat_d;
                end
            end

            assign rvalid_o[gi] = s2_vld_q;
            assign rdata_o[port_slice(gi, DATA_WIDTH) +: DATA_WIDTH] = s2_dat_q;
        end else begin : g_lat1
            assign rvalid_o[gi] = s1_vld_q;
            assign rdata_o[port_slice(gi, DATA_WIDTH) +: DATA_WIDTH] = s1_dat_q;
        end
    end

endmodule
